// File: rtl/key_select_encoder_if.sv
// rtl/key_select_encoder_if.sv - selector valid/ack handshake between the key encoder and the ROM-write logic
//
// Purpose: carries the encoded word selector from the front-panel encoder to its consumer.
// Signals:
//   selector   4-bit encoded ROM word index       (master -> slave)
//   sel_valid  selector holds an unconsumed press (master -> slave)
//   sel_ack    consumer accepts the selector      (slave -> master)
interface key_select_encoder_if;
  logic [3:0] selector;
  logic       sel_valid;
  logic       sel_ack;

  modport master (output selector, output sel_valid, input sel_ack);
  modport slave  (input selector, input sel_valid, output sel_ack);
endinterface

// File: rtl/key_select_encoder.sv
// rtl/key_select_encoder.sv - front-panel 16-key synchroniser, debouncer and one-hot to index encoder
//
// Purpose: turns a single debounced push-button press into a 4-bit ROM word selector,
// offered on a valid/ack handshake. Only input mode (mode == 0) produces events.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mode       0 = input, 1 = run, 2 = debug, 3 = reserved (non-input)
//   key        raw button lines, active-high, bit i = ROM word i
//   sel        selector / sel_valid / sel_ack handshake (master side)
//   multi_err  last debounced press had two or more keys
//   overrun    sticky: a press arrived while sel_valid was still high
module key_select_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic [15:0]                key,
  key_select_encoder_if.master       sel,
  output logic                       multi_err,
  output logic                       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RELEASED, HELD} state_t;

  logic [15:0]      key_m;   // first synchroniser stage
  logic [15:0]      key_s;   // synchronised key vector
  logic [15:0]      key_p;   // key_s one cycle earlier
  logic [15:0]      key_d;   // debounced key vector
  logic [CNT_W-1:0] cnt;
  state_t           state;

  logic             one_hot;
  logic [3:0]       idx;

  // Synchroniser and debounce. key_d only loads while key_s is still equal to
  // its previous value, so a change arriving while cnt sits at its saturation
  // value cannot slip through on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_m <= '0;
      key_s <= '0;
      key_p <= '0;
      key_d <= '0;
      cnt   <= '0;
    end else begin
      key_m <= key;
      key_s <= key_m;
      key_p <= key_s;
      if (key_s != key_p)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
      if (key_s == key_p && cnt == CNT_MAX)
        key_d <= key_s;
    end
  end

  always_comb begin
    one_hot = (key_d != 16'd0) && ((key_d & (key_d - 16'd1)) == 16'd0);
    idx     = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_d[i])
        idx = 4'(i);
    end
  end

  // Press FSM with registered outputs. Later assignments take priority:
  // ack clears sel_valid, a new accepted press re-sets it, and any non-input
  // mode forces it low regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RELEASED;
      sel.selector  <= 4'd0;
      sel.sel_valid <= 1'b0;
      multi_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (sel.sel_ack && sel.sel_valid)
        sel.sel_valid <= 1'b0;

      case (state)
        RELEASED: begin
          if (key_d != 16'd0) begin
            state <= HELD;
            if (mode == 2'd0) begin
              if (one_hot) begin
                sel.selector  <= idx;
                sel.sel_valid <= 1'b1;
                multi_err     <= 1'b0;
                if (sel.sel_valid && !sel.sel_ack)
                  overrun <= 1'b1;
              end else begin
                multi_err <= 1'b1;
              end
            end
          end
        end
        HELD: begin
          // A key change without a full release never produces a new event.
          if (key_d == 16'd0)
            state <= RELEASED;
        end
        default: state <= RELEASED;
      endcase

      if (mode != 2'd0)
        sel.sel_valid <= 1'b0;
    end
  end

endmodule
